// File: rtl/tick_sched_pkg.sv
// Shared constants and config FSM encoding
// for the three-channel tick scheduler.
package tick_sched_pkg;

  localparam int CNT_W = 27;
  localparam int NCH = 3;

  localparam int HALF0_INIT = 25000;
  localparam int HALF1_INIT = 5000;
  localparam int HALF2_INIT = 25000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/tick_scheduler_div.sv
// One divider channel: counter, half-period,
// enable, divided clock level and tick pulse.
module div_channel #(
  parameter int W = 27,
  parameter int HALF_INIT = 25000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         apply,
  input  logic [W-1:0] new_half,
  input  logic         new_en,
  output logic         boundary,
  output logic         level,
  output logic         running,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic [W-1:0] half_q;

  assign boundary = running && (cnt == half_q - W'(1));

  // Apply only swaps half/enable; the toggle at the
  // boundary itself always uses the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      half_q  <= W'(HALF_INIT);
      running <= 1'b1;
      level   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (!running) begin
        cnt   <= '0;
        level <= 1'b0;
        tick  <= 1'b0;
      end else if (boundary) begin
        cnt   <= '0;
        level <= ~level;
        tick  <= 1'b1;
      end else begin
        cnt  <= cnt + W'(1);
        tick <= 1'b0;
      end
      if (apply) begin
        half_q  <= new_half;
        running <= new_en;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Config FSM, shadow register and apply-point
// selection around three divider channels.
module tick_scheduler #(
  parameter int CNT_W = tick_sched_pkg::CNT_W,
  parameter int HALF0_INIT = tick_sched_pkg::HALF0_INIT,
  parameter int HALF1_INIT = tick_sched_pkg::HALF1_INIT,
  parameter int HALF2_INIT = tick_sched_pkg::HALF2_INIT
) (
  input  logic             Clk_50M,
  input  logic             Rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_en,
  output logic             cfg_err,
  output logic [2:0]       clk_out,
  output logic [2:0]       tick
);

  import tick_sched_pkg::*;

  cfg_state_t state;
  cfg_state_t state_nx;

  logic [1:0]       sh_ch;
  logic [CNT_W-1:0] sh_half;
  logic             sh_en;

  logic accept;
  logic bad;

  logic [NCH-1:0] boundary;
  logic [NCH-1:0] running;
  logic [NCH-1:0] apply;

  assign accept = cfg_valid & cfg_ready;
  assign bad = (cfg_ch == 2'd3) ||
               (cfg_half < CNT_W'(2));

  // A stopped channel applies at once; a running one
  // waits for a boundary, and for a disable only the
  // falling one so it stops low.
  always_comb begin
    apply = '0;
    for (int i = 0; i < NCH; i++) begin
      if (state == PEND && sh_ch == 2'(i)) begin
        apply[i] = !running[i] ||
                   (boundary[i] &&
                    (sh_en || clk_out[i]));
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && !bad) state_nx = PEND;
      PEND: if (|apply) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk_50M) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      sh_ch     <= '0;
      sh_half   <= '0;
      sh_en     <= 1'b0;
    end else begin
      state     <= state_nx;
      cfg_ready <= (state_nx == IDLE);
      cfg_err   <= accept && bad;
      if (accept && !bad) begin
        sh_ch   <= cfg_ch;
        sh_half <= cfg_half;
        sh_en   <= cfg_en;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    div_channel #(
      .W(CNT_W),
      .HALF_INIT(g == 0 ? HALF0_INIT :
                 g == 1 ? HALF1_INIT : HALF2_INIT)
    ) u_ch (
      .clk(Clk_50M),
      .rst_n(Rst_n),
      .apply(apply[g]),
      .new_half(sh_half),
      .new_en(sh_en),
      .boundary(boundary[g]),
      .level(clk_out[g]),
      .running(running[g]),
      .tick(tick[g])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench: a time-based channel model
// predicts outputs, a monitor compares each cycle.
module tb_tick_scheduler;

  localparam int W = 27;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [1:0]   cfg_ch;
  logic [W-1:0] cfg_half;
  logic         cfg_en;
  logic         cfg_err;
  logic [2:0]   clk_out;
  logic [2:0]   tick;

  int checks = 0;
  int errors = 0;

  tick_scheduler #(
    .CNT_W(W),
    .HALF0_INIT(4),
    .HALF1_INIT(5),
    .HALF2_INIT(8)
  ) dut (
    .Clk_50M(clk),
    .Rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_half(cfg_half),
    .cfg_en(cfg_en),
    .cfg_err(cfg_err),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Model: each channel knows the absolute cycle of
  // its next toggle; a toggle schedules the next one
  // half cycles later.
  int init_half [3] = '{4, 5, 8};
  int m_half [3];
  int m_nxt [3];
  logic [2:0] m_en, m_lvl, m_tk, was;
  logic m_ready, m_err;
  int cyc, rdy_at;
  bit pend;
  int sh_ch, sh_half;
  bit sh_en;
  logic [7:0] expq [$];

  always @(posedge clk) begin
    bit acc, done;
    if (!rst_n) begin
      cyc = 0;
      for (int c = 0; c < 3; c++) begin
        m_half[c] = init_half[c];
        m_nxt[c] = init_half[c];
      end
      m_en = 3'b111;
      m_lvl = 3'b000;
      m_tk = 3'b000;
      m_ready = 1'b0;
      m_err = 1'b0;
      pend = 0;
      rdy_at = 1;
    end else begin
      cyc++;
      acc = cfg_valid && m_ready;
      m_err = 1'b0;
      for (int c = 0; c < 3; c++) begin
        was[c] = m_lvl[c];
        m_tk[c] = m_en[c] && (cyc == m_nxt[c]);
        if (m_tk[c]) begin
          m_lvl[c] = ~m_lvl[c];
          m_nxt[c] = cyc + m_half[c];
        end
      end
      if (pend) begin
        done = 0;
        if (!m_en[sh_ch]) begin
          m_half[sh_ch] = sh_half;
          if (sh_en) begin
            m_en[sh_ch] = 1'b1;
            m_lvl[sh_ch] = 1'b0;
            m_nxt[sh_ch] = cyc + sh_half;
          end
          done = 1;
        end else if (m_tk[sh_ch] &&
                     (sh_en || was[sh_ch])) begin
          m_half[sh_ch] = sh_half;
          m_nxt[sh_ch] = cyc + sh_half;
          if (!sh_en) begin
            m_en[sh_ch] = 1'b0;
            m_lvl[sh_ch] = 1'b0;
          end
          done = 1;
        end
        if (done) begin
          pend = 0;
          rdy_at = cyc + 1;
        end
      end
      if (cyc == rdy_at) m_ready = 1'b1;
      if (acc) begin
        if (cfg_ch == 2'd3 || int'(cfg_half) < 2) begin
          m_err = 1'b1;
        end else begin
          pend = 1;
          sh_ch = int'(cfg_ch);
          sh_half = int'(cfg_half);
          sh_en = cfg_en;
          m_ready = 1'b0;
        end
      end
    end
    expq.push_back({m_lvl, m_tk, m_ready, m_err});
  end

  always @(negedge clk) begin
    logic [7:0] e, g;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      g = {clk_out, tick, cfg_ready, cfg_err};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got clk_out=%b tick=%b rdy=%b err=%b want clk_out=%b tick=%b rdy=%b err=%b",
                 $time, g[7:5], g[4:2], g[1], g[0],
                 e[7:5], e[4:2], e[1], e[0]);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_ready && n < 300) begin
      cycles(1);
      n++;
    end
    checks++;
    if (!cfg_ready) begin
      errors++;
      $display("FAIL ready_timeout got %b want 1",
               cfg_ready);
    end
  endtask

  task automatic send(input int ch, input int half,
                      input bit en);
    wait_ready();
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_half = W'(half);
    cfg_en = en;
    cycles(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_for(input int ch, input bit lvl,
                          input bit use_tick);
    int n = 0;
    while (n < 200 &&
           ((use_tick ? tick[ch] : clk_out[ch]) !== lvl))
    begin
      cycles(1);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_ch%0d timeout want %b", ch, lvl);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_half = '0;
    cfg_en = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(21);
    send(0, 6, 1'b1);
    cycles(30);
    wait_ready();
    wait_for(1, 1'b0, 1'b0);
    send(1, 5, 1'b0);
    cycles(70);
    send(1, 3, 1'b1);
    cycles(20);
    send(3, 7, 1'b1);
    cycles(3);
    send(0, 1, 1'b1);
    cycles(5);
    wait_ready();
    wait_for(2, 1'b1, 1'b1);
    cycles(7);
    send(2, 5, 1'b1);
    cycles(30);
    send(0, 10, 1'b1);
    cycles(1);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(30);
    for (int i = 0; i < 25; i++) begin
      cycles($urandom_range(0, 10));
      send($urandom_range(0, 3), $urandom_range(0, 9),
           1'($urandom_range(0, 1)));
    end
    cycles(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
